// File: rtl/wr_dac_pkg.sv
// Shared types and constants for the VCXO tuning DAC arbiter and its SPI shifter.
package wr_dac_pkg;

    localparam int unsigned c_dac_frame_bits = 24;
    localparam int unsigned c_dac_data_bits  = 16;
    localparam logic [1:0]  c_dac_pd_normal  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOOT,
        ST_GRANT,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } t_dac_arb_state;

    typedef enum logic [1:0] {
        SRC_LOOP,
        SRC_MANUAL,
        SRC_BOOT
    } t_dac_src;

    // AD5662 input shift register layout, bit 23 leaves first
    typedef struct packed {
        logic [5:0]                 rsvd;
        logic [1:0]                 pd;
        logic [c_dac_data_bits-1:0] code;
    } t_dac_frame;

    // Counter width able to hold the larger of two cycle counts (with headroom bit)
    function automatic int unsigned f_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/spi_dac_shifter.sv
// Serializes one 24-bit DAC frame: ncs low, sclk idles high, din changes on sclk rise,
// DAC samples on sclk fall; one extra high half-period before ncs is released.
module spi_dac_shifter
    import wr_dac_pkg::*;
#(
    parameter int unsigned g_sclk_div = 4
) (
    input  logic       clk_sys_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  t_dac_frame word_i,
    output logic       finish_c_o,
    output logic       dac_ncs_o,
    output logic       dac_sclk_o,
    output logic       dac_din_o
);

    localparam int unsigned              c_div_w    = f_cnt_width(g_sclk_div, 1);
    localparam logic [c_div_w-1:0]       c_div_last = c_div_w'(g_sclk_div - 1);
    localparam logic [4:0]               c_bit_last = 5'(c_dac_frame_bits - 1);

    logic                        active_q;
    logic                        tail_q;
    logic                        low_q;
    logic [c_div_w-1:0]          div_q;
    logic [4:0]                  bit_q;
    logic [c_dac_frame_bits-1:0] sr_q;
    logic                        ncs_q;
    logic                        sclk_q;
    logic                        din_q;
    logic                        phase_end_c;

    assign phase_end_c = active_q && (div_q == c_div_last);
    assign finish_c_o  = phase_end_c && tail_q;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_q <= 1'b0;
            tail_q   <= 1'b0;
            low_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            ncs_q    <= 1'b1;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
        end else if (start_i && !active_q) begin
            active_q <= 1'b1;
            tail_q   <= 1'b0;
            low_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sr_q     <= {word_i[c_dac_frame_bits-2:0], 1'b0};
            ncs_q    <= 1'b0;
            sclk_q   <= 1'b1;
            din_q    <= word_i[c_dac_frame_bits-1];
        end else if (active_q) begin
            if (!phase_end_c) begin
                div_q <= div_q + c_div_w'(1);
            end else begin
                div_q <= '0;
                if (tail_q) begin
                    active_q <= 1'b0;
                    tail_q   <= 1'b0;
                    ncs_q    <= 1'b1;
                    din_q    <= 1'b0;
                end else if (!low_q) begin
                    low_q  <= 1'b1;
                    sclk_q <= 1'b0;
                end else if (bit_q == c_bit_last) begin
                    // last bit sampled: one more high half-period before deselect
                    low_q  <= 1'b0;
                    sclk_q <= 1'b1;
                    tail_q <= 1'b1;
                end else begin
                    low_q  <= 1'b0;
                    sclk_q <= 1'b1;
                    bit_q  <= bit_q + 5'd1;
                    din_q  <= sr_q[c_dac_frame_bits-1];
                    sr_q   <= {sr_q[c_dac_frame_bits-2:0], 1'b0};
                end
            end
        end
    end

    assign dac_ncs_o  = ncs_q;
    assign dac_sclk_o = sclk_q;
    assign dac_din_o  = din_q;

endmodule

// File: rtl/vcxo_dac_arbiter.sv
// Shares the VCXO tuning DAC between the softPLL loop and a host override:
// coalesces pending writes, arbitrates round-robin, issues a boot write, reports last code.
module vcxo_dac_arbiter
    import wr_dac_pkg::*;
#(
    parameter int unsigned g_sclk_div   = 4,
    parameter int unsigned g_gap_cycles = 8,
    parameter int unsigned g_boot_write = 1,
    parameter logic [15:0] g_init_value = 16'h8000
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic [15:0] loop_value_i,
    input  logic        loop_load_i,
    input  logic [15:0] manual_value_i,
    input  logic        manual_load_i,
    input  logic        manual_en_i,
    output logic        loop_ovr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] cur_value_o,
    output logic        dac_ncs_o,
    output logic        dac_sclk_o,
    output logic        dac_din_o
);

    localparam int unsigned        c_cnt_w    = f_cnt_width(g_sclk_div, g_gap_cycles);
    localparam int unsigned        c_gap_len  = (g_gap_cycles > 2 * g_sclk_div) ?
                                                g_gap_cycles : 2 * g_sclk_div;
    // HOLD accounts for the first deselected cycle, the counter covers the rest
    localparam logic [c_cnt_w-1:0] c_gap_load = c_cnt_w'(c_gap_len - 2);

    t_dac_arb_state              state_q;
    logic                        loop_pend_q;
    logic [c_dac_data_bits-1:0]  loop_val_q;
    logic                        man_pend_q;
    logic [c_dac_data_bits-1:0]  man_val_q;
    logic                        boot_pend_q;
    t_dac_src                    rr_last_q;
    logic [c_cnt_w-1:0]          gap_q;
    logic [c_dac_data_bits-1:0]  code_q;
    logic [c_dac_data_bits-1:0]  cur_value_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        loop_ovr_q;

    logic                        loop_elig_c;
    logic                        grant_c;
    t_dac_src                    grant_src_c;
    logic [c_dac_data_bits-1:0]  grant_code_c;
    t_dac_frame                  frame_c;
    logic                        shift_finish_c;

    assign loop_elig_c = loop_pend_q && !manual_en_i;

    // Arbitration: boot write first, then round-robin between eligible requesters
    always_comb begin
        grant_c      = 1'b0;
        grant_src_c  = SRC_LOOP;
        grant_code_c = loop_val_q;
        if (state_q == ST_IDLE) begin
            if (boot_pend_q) begin
                grant_c     = 1'b1;
                grant_src_c = SRC_BOOT;
            end else if (man_pend_q && (!loop_elig_c || rr_last_q == SRC_LOOP)) begin
                grant_c     = 1'b1;
                grant_src_c = SRC_MANUAL;
            end else if (loop_elig_c) begin
                grant_c     = 1'b1;
                grant_src_c = SRC_LOOP;
            end
        end
        case (grant_src_c)
            SRC_MANUAL: grant_code_c = man_val_q;
            SRC_BOOT:   grant_code_c = g_init_value;
            default:    grant_code_c = loop_val_q;
        endcase
    end

    assign frame_c = '{rsvd: 6'd0, pd: c_dac_pd_normal, code: grant_code_c};

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            loop_pend_q <= 1'b0;
            loop_val_q  <= '0;
            man_pend_q  <= 1'b0;
            man_val_q   <= '0;
            boot_pend_q <= (g_boot_write != 0);
            rr_last_q   <= SRC_LOOP;
            gap_q       <= '0;
            code_q      <= '0;
            cur_value_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            loop_ovr_q  <= 1'b0;
        end else begin
            done_q     <= shift_finish_c;
            loop_ovr_q <= loop_load_i && loop_pend_q &&
                          !(grant_c && grant_src_c == SRC_LOOP);

            // A load in the grant cycle stays pending; the old word is the one sent
            if (loop_load_i) begin
                loop_pend_q <= 1'b1;
                loop_val_q  <= loop_value_i;
            end else if (grant_c && grant_src_c == SRC_LOOP) begin
                loop_pend_q <= 1'b0;
            end
            if (manual_load_i) begin
                man_pend_q <= 1'b1;
                man_val_q  <= manual_value_i;
            end else if (grant_c && grant_src_c == SRC_MANUAL) begin
                man_pend_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_c) begin
                        busy_q <= 1'b1;
                        code_q <= grant_code_c;
                        if (grant_src_c == SRC_BOOT) begin
                            state_q     <= ST_BOOT;
                            boot_pend_q <= 1'b0;
                        end else begin
                            state_q   <= ST_GRANT;
                            rr_last_q <= grant_src_c;
                        end
                    end
                end
                ST_BOOT, ST_GRANT: begin
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (shift_finish_c) begin
                        state_q     <= ST_HOLD;
                        cur_value_q <= code_q;
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_GAP;
                    gap_q   <= c_gap_load;
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - c_cnt_w'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    spi_dac_shifter #(
        .g_sclk_div (g_sclk_div)
    ) u_shifter (
        .clk_sys_i  (clk_sys_i),
        .rst_n_i    (rst_n_i),
        .start_i    (grant_c),
        .word_i     (frame_c),
        .finish_c_o (shift_finish_c),
        .dac_ncs_o  (dac_ncs_o),
        .dac_sclk_o (dac_sclk_o),
        .dac_din_o  (dac_din_o)
    );

    assign loop_ovr_o  = loop_ovr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cur_value_o = cur_value_q;

endmodule

// File: tb/tb_vcxo_dac_arbiter.sv
// Scoreboard bench: a frame-level model predicts which codes reach the DAC and when;
// a pin monitor decodes SPI frames and compares them against the expected queue.
module tb_vcxo_dac_arbiter;

    localparam int unsigned D         = 4;
    localparam int unsigned GAP       = 8;
    localparam int unsigned N_GAP     = (GAP > 2 * D) ? GAP : 2 * D;
    localparam int unsigned FRAME_LOW = 49 * D;
    localparam logic [15:0] INIT      = 16'h8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] loop_value = 16'h0;
    logic        loop_load = 1'b0;
    logic [15:0] manual_value = 16'h0;
    logic        manual_load = 1'b0;
    logic        manual_en = 1'b0;
    logic        loop_ovr;
    logic        busy;
    logic        done;
    logic [15:0] cur_value;
    logic        dac_ncs;
    logic        dac_sclk;
    logic        dac_din;

    vcxo_dac_arbiter #(
        .g_sclk_div   (D),
        .g_gap_cycles (GAP),
        .g_boot_write (1),
        .g_init_value (INIT)
    ) dut (
        .clk_sys_i      (clk),
        .rst_n_i        (rst_n),
        .loop_value_i   (loop_value),
        .loop_load_i    (loop_load),
        .manual_value_i (manual_value),
        .manual_load_i  (manual_load),
        .manual_en_i    (manual_en),
        .loop_ovr_o     (loop_ovr),
        .busy_o         (busy),
        .done_o         (done),
        .cur_value_o    (cur_value),
        .dac_ncs_o      (dac_ncs),
        .dac_sclk_o     (dac_sclk),
        .dac_din_o      (dac_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] code;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame occupancy as a time window, pendings as newest-wins slots
    bit          m_boot = 1'b1;
    bit          m_lpend = 1'b0;
    bit          m_mpend = 1'b0;
    logic [15:0] m_lval = 16'h0;
    logic [15:0] m_mval = 16'h0;
    bit          m_last_man = 1'b0;
    int          m_free_at = 0;
    bit          m_ovr_exp = 1'b0;
    bit          m_g;
    bit          m_gl;
    bit          m_el;
    logic [15:0] m_code;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_boot     = 1'b1;
            m_lpend    = 1'b0;
            m_mpend    = 1'b0;
            m_last_man = 1'b0;
            m_free_at  = 0;
            m_ovr_exp  = 1'b0;
            cyc        = 0;
            exp_q.delete();
        end else begin
            m_g    = 1'b0;
            m_gl   = 1'b0;
            m_code = 16'h0;
            m_el   = m_lpend && !manual_en;
            if (cyc >= m_free_at) begin
                if (m_boot) begin
                    m_g    = 1'b1;
                    m_code = INIT;
                    m_boot = 1'b0;
                end else if (m_mpend && (!m_el || !m_last_man)) begin
                    m_g        = 1'b1;
                    m_code     = m_mval;
                    m_mpend    = 1'b0;
                    m_last_man = 1'b1;
                end else if (m_el) begin
                    m_g        = 1'b1;
                    m_gl       = 1'b1;
                    m_code     = m_lval;
                    m_last_man = 1'b0;
                end
            end
            m_ovr_exp = loop_load && m_lpend && !m_gl;
            if (m_g) begin
                exp_q.push_back('{m_code, cyc + 1});
                m_free_at = cyc + 1 + int'(FRAME_LOW) + int'(N_GAP);
            end
            if (m_gl) m_lpend = 1'b0;
            if (loop_load) begin
                m_lpend = 1'b1;
                m_lval  = loop_value;
            end
            if (manual_load) begin
                m_mpend = 1'b1;
                m_mval  = manual_value;
            end
            cyc++;
        end
    end

    // Pin monitor: a DAC that samples din on sclk falling edges
    bit          prev_ncs = 1'b1;
    bit          prev_sclk = 1'b1;
    bit          prev_busy = 1'b0;
    int          nbits = 0;
    logic [23:0] word = 24'h0;
    int          fall_cyc = 0;
    int          last_rise = 0;
    bit          last_rise_valid = 1'b0;
    int          ovr_cnt = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ncs        = 1'b1;
            prev_sclk       = 1'b1;
            prev_busy       = 1'b0;
            nbits           = 0;
            last_rise_valid = 1'b0;
        end else begin
            if (loop_ovr === 1'b1) ovr_cnt++;
            if (loop_ovr === 1'b1 || m_ovr_exp) check("loop_ovr", 32'(loop_ovr), 32'(m_ovr_exp));
            if (prev_ncs && dac_ncs === 1'b0) begin
                fall_cyc = cyc;
                nbits    = 0;
                word     = 24'h0;
                if (last_rise_valid) begin
                    vectors++;
                    if (cyc - last_rise < int'(GAP)) begin
                        miscompares++;
                        $display("FAIL ncs_gap: got %0d high cycles, expected >= %0d", cyc - last_rise, GAP);
                    end
                end
            end
            if (dac_ncs === 1'b0 && prev_sclk && dac_sclk === 1'b0) begin
                word = {word[22:0], dac_din};
                nbits++;
            end
            if (!prev_ncs && dac_ncs === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got word 0x%0h, expected no frame", word);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", 32'(nbits), 32'd24);
                    check("frame_word", {8'h00, word}, {16'h0000, e.code});
                    check("ncs_fall_cycle", 32'(fall_cyc), 32'(e.t0));
                    check("ncs_low_len", 32'(cyc - fall_cyc), 32'(FRAME_LOW));
                    check("done_pulse", 32'(done), 32'd1);
                    check("cur_value", 32'(cur_value), {16'h0000, e.code});
                end
                last_rise       = cyc;
                last_rise_valid = 1'b1;
            end else if (done === 1'b1) begin
                check("done_spurious", 32'(done), 32'd0);
            end
            if (dac_ncs === 1'b1) check("idle_pins", {30'h0, dac_sclk, dac_din}, 32'h2);
            if (!prev_busy && busy === 1'b1) check("busy_rise_ncs", 32'(dac_ncs), 32'd0);
            if (prev_busy && busy === 1'b0 && last_rise_valid)
                check("busy_drop", 32'(cyc - last_rise), 32'(N_GAP));
            prev_ncs  = (dac_ncs === 1'b1);
            prev_sclk = (dac_sclk === 1'b1);
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic load_loop(input logic [15:0] v);
        @(negedge clk);
        loop_value = v;
        loop_load  = 1'b1;
        @(negedge clk);
        loop_load  = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && (cyc >= m_free_at) && !m_boot && !m_mpend &&
                 !(m_lpend && !manual_en);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: timeout with %0d frames outstanding", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ovr_base;
        bit hit;

        repeat (3) @(negedge clk);
        check("rst_ncs", 32'(dac_ncs), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd1);
        check("rst_din", 32'(dac_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovr", 32'(loop_ovr), 32'd0);
        check("rst_cur", 32'(cur_value), 32'd0);
        rst_n = 1'b1;

        // boot frame
        wait_idle();
        check("boot_cur_value", 32'(cur_value), 32'h8000);

        // single loop write from idle
        load_loop(16'h1234);
        wait_idle();

        // overwrite of an unsent loop word
        ovr_base = ovr_cnt;
        load_loop(16'h0AAA);
        repeat (20) @(negedge clk);
        load_loop(16'h1111);
        repeat (5) @(negedge clk);
        load_loop(16'h2222);
        wait_idle();
        check("ovr_pulse_count", 32'(ovr_cnt - ovr_base), 32'd1);

        // both pending in the same cycle after a loop grant: manual goes first
        @(negedge clk);
        loop_value   = 16'h3333;
        loop_load    = 1'b1;
        manual_value = 16'hC0DE;
        manual_load  = 1'b1;
        @(negedge clk);
        loop_load    = 1'b0;
        manual_load  = 1'b0;
        wait_idle();

        // manual ownership holds off the loop word until released
        manual_en = 1'b1;
        load_loop(16'h4444);
        repeat (300) @(negedge clk);
        check("held_ncs_idle", 32'(dac_ncs), 32'd1);
        manual_en = 1'b0;
        wait_idle();

        // reset mid-frame, with a stale pending word queued behind it
        load_loop(16'h5555);
        load_loop(16'h6666);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            hit = (nbits == 10);
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL reach_bit10: never reached bit 10 of frame");
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ncs", 32'(dac_ncs), 32'd1);
        check("midrst_sclk", 32'(dac_sclk), 32'd1);
        check("midrst_din", 32'(dac_din), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        check("postrst_cur_value", 32'(cur_value), 32'h8000);

        // continuous loop loads with random manual traffic and ownership changes
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            loop_value   = 16'($urandom);
            loop_load    = 1'b1;
            manual_value = 16'($urandom);
            manual_load  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) manual_en = ~manual_en;
        end
        @(negedge clk);
        loop_load   = 1'b0;
        manual_load = 1'b0;
        manual_en   = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
